// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Registered round-robin arbiter between CPUS instruction/data cache pairs
//   and a single-ported RAM. In IDLE one requesting channel is picked
//   (round-robin over CPUs, data ahead of instruction within a CPU). The
//   grant is then held until the RAM answers ACCESS or the owner withdraws.
//
// Ports
//   CLK, nRST              clock (rising edge), async active-low reset
//   iREN/iaddr             per-CPU instruction read request and address
//   iwait/iload            per-CPU instruction wait and read data
//   dREN/dWEN/daddr/dstore per-CPU data read/write request, address, data
//   dwait/dload            per-CPU data wait and read data
//   ramstate/ramload       RAM status (FREE/BUSY/ACCESS/ERROR) and read data
//   ramREN/ramWEN          RAM read/write enables
//   ramaddr/ramstore       RAM address and write data
module mem_arbiter #(
  parameter int CPUS = 2,
  parameter int AW   = 32,
  parameter int DW   = 32
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic [CPUS-1:0]          iREN,
  input  logic [CPUS-1:0][AW-1:0]  iaddr,
  output logic [CPUS-1:0]          iwait,
  output logic [CPUS-1:0][DW-1:0]  iload,
  input  logic [CPUS-1:0]          dREN,
  input  logic [CPUS-1:0]          dWEN,
  input  logic [CPUS-1:0][AW-1:0]  daddr,
  input  logic [CPUS-1:0][DW-1:0]  dstore,
  output logic [CPUS-1:0]          dwait,
  output logic [CPUS-1:0][DW-1:0]  dload,
  input  logic [1:0]               ramstate,
  input  logic [DW-1:0]            ramload,
  output logic                     ramREN,
  output logic                     ramWEN,
  output logic [AW-1:0]            ramaddr,
  output logic [DW-1:0]            ramstore
);

  localparam int OW = (CPUS > 1) ? $clog2(CPUS) : 1;
  localparam logic [1:0] RAM_ACCESS = 2'd2;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        state, statenext;
  logic [OW-1:0] owner, ownernext;
  logic [OW-1:0] rr_ptr, rrnext;
  logic          chan, channext;

  logic [CPUS-1:0] reqd, reqi;
  logic            found;
  logic [OW-1:0]   pickcpu;
  logic            pickchan;
  logic            ownerreq;
  logic            granted;
  logic [OW-1:0]   rrafter;

  assign reqd     = dREN | dWEN;
  assign reqi     = iREN;
  assign granted  = (state == GRANT);
  assign ownerreq = chan ? reqd[owner] : reqi[owner];
  // Pointer moves past the owner whether it completed or withdrew.
  assign rrafter  = (owner == OW'(CPUS - 1)) ? '0 : owner + 1'b1;

  // Round-robin scan starting at rr_ptr; first CPU with any request wins.
  always_comb begin
    logic [OW-1:0] idx;
    found    = 1'b0;
    pickcpu  = '0;
    pickchan = 1'b0;
    idx      = '0;
    for (int k = 0; k < CPUS; k++) begin
      idx = OW'((int'(rr_ptr) + k) % CPUS);
      if (!found && (reqd[idx] || reqi[idx])) begin
        found    = 1'b1;
        pickcpu  = idx;
        pickchan = reqd[idx];
      end
    end
  end

  // State register: async reset abandons any in-flight transaction.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state  <= IDLE;
      owner  <= '0;
      chan   <= 1'b0;
      rr_ptr <= '0;
    end else begin
      state  <= statenext;
      owner  <= ownernext;
      chan   <= channext;
      rr_ptr <= rrnext;
    end
  end

  // Next-state logic: latch the winner in IDLE, release on ACCESS or withdrawal.
  always_comb begin
    statenext = state;
    ownernext = owner;
    channext  = chan;
    rrnext    = rr_ptr;
    unique case (state)
      IDLE: begin
        if (found) begin
          statenext = GRANT;
          ownernext = pickcpu;
          channext  = pickchan;
        end
      end
      GRANT: begin
        if (!ownerreq || ramstate == RAM_ACCESS) begin
          statenext = IDLE;
          rrnext    = rrafter;
        end
      end
      default: statenext = IDLE;
    endcase
  end

  // RAM drive: address/data pass through live; enables drop as soon as the
  // owner withdraws its request.
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    if (granted) begin
      if (chan) begin
        ramaddr = daddr[owner];
        if (dWEN[owner]) begin
          ramWEN   = ownerreq;
          ramstore = dstore[owner];
        end else begin
          ramREN = ownerreq;
        end
      end else begin
        ramaddr = iaddr[owner];
        ramREN  = ownerreq;
      end
    end
  end

  // Waits follow the request except in the owner's ACCESS cycle.
  for (genvar i = 0; i < CPUS; i++) begin : g_cpu
    logic ownsnow;
    assign ownsnow  = granted && (owner == OW'(i)) && (ramstate == RAM_ACCESS);
    assign iwait[i] = iREN[i] & ~(ownsnow & ~chan);
    assign dwait[i] = reqd[i] & ~(ownsnow & chan);
    assign iload[i] = ramload;
    assign dload[i] = ramload;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Directed-vector bench for mem_arbiter with CPUS=2, AW=DW=32. Inputs are
//   driven just after each rising edge and outputs observed a little later
//   in the same cycle.
module tb_mem_arbiter;

  logic             CLK;
  logic             nRST;
  logic [1:0]       iREN;
  logic [1:0][31:0] iaddr;
  logic [1:0]       iwait;
  logic [1:0][31:0] iload;
  logic [1:0]       dREN;
  logic [1:0]       dWEN;
  logic [1:0][31:0] daddr;
  logic [1:0][31:0] dstore;
  logic [1:0]       dwait;
  logic [1:0][31:0] dload;
  logic [1:0]       ramstate;
  logic [31:0]      ramload;
  logic             ramREN;
  logic             ramWEN;
  logic [31:0]      ramaddr;
  logic [31:0]      ramstore;

  int checkCount = 0;
  int passCount  = 0;

  localparam logic [1:0] FREE   = 2'd0;
  localparam logic [1:0] BUSY   = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] ERROR  = 2'd3;

  mem_arbiter #(.CPUS(2), .AW(32), .DW(32)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramstate(ramstate), .ramload(ramload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
  endtask

  task automatic applyStimulus(input logic cpu, input logic ir, input logic [31:0] ia,
                               input logic dr, input logic dw,
                               input logic [31:0] da, input logic [31:0] ds);
    iREN[cpu]   = ir;
    iaddr[cpu]  = ia;
    dREN[cpu]   = dr;
    dWEN[cpu]   = dw;
    daddr[cpu]  = da;
    dstore[cpu] = ds;
  endtask

  task automatic nextCycle();
    @(posedge CLK);
    #1;
  endtask

  logic [31:0] expAddr  [8];
  logic [1:0]  expDwait [8];

  initial begin
    expAddr  = '{32'h0, 32'hB0, 32'h0, 32'hA0, 32'h0, 32'hB0, 32'h0, 32'hA0};
    expDwait = '{2'b11, 2'b01, 2'b11, 2'b10, 2'b11, 2'b01, 2'b11, 2'b10};

    nRST     = 1'b0;
    iREN     = '0; iaddr  = '0;
    dREN     = '0; dWEN   = '0;
    daddr    = '0; dstore = '0;
    ramstate = FREE;
    ramload  = '0;
    #2;
    checkOutput("rst_ramREN",  32'(ramREN),  32'h0);
    checkOutput("rst_ramWEN",  32'(ramWEN),  32'h0);
    checkOutput("rst_ramaddr", ramaddr,      32'h0);
    checkOutput("rst_iwait",   32'(iwait),   32'h0);
    checkOutput("rst_dwait",   32'(dwait),   32'h0);
    @(posedge CLK); @(posedge CLK); #1;
    nRST = 1'b1;

    // Instruction read, two BUSY cycles then ACCESS
    nextCycle();
    applyStimulus(1'b0, 1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0);
    ramstate = BUSY;
    #1;
    checkOutput("i_idle_ramREN", 32'(ramREN), 32'h0);
    checkOutput("i_idle_iwait",  32'(iwait),  32'h1);
    nextCycle(); #1;
    checkOutput("i_g1_ramREN",  32'(ramREN), 32'h1);
    checkOutput("i_g1_ramaddr", ramaddr,     32'h100);
    checkOutput("i_g1_iwait",   32'(iwait),  32'h1);
    nextCycle(); #1;
    checkOutput("i_g2_iwait",   32'(iwait),  32'h1);
    nextCycle();
    ramstate = ACCESS;
    ramload  = 32'h12345678;
    #1;
    checkOutput("i_acc_iwait", 32'(iwait), 32'h0);
    checkOutput("i_acc_iload", iload[0],   32'h12345678);

    // CPU0 write plus instruction read together: D first, I after bubble
    nextCycle();
    applyStimulus(1'b0, 1'b1, 32'h300, 1'b0, 1'b1, 32'h200, 32'hDEADBEEF);
    #1;
    checkOutput("dw_idle_ramREN", 32'(ramREN), 32'h0);
    checkOutput("dw_idle_dwait",  32'(dwait),  32'h1);
    nextCycle(); #1;
    checkOutput("dw_g_ramWEN",   32'(ramWEN), 32'h1);
    checkOutput("dw_g_ramREN",   32'(ramREN), 32'h0);
    checkOutput("dw_g_ramaddr",  ramaddr,     32'h200);
    checkOutput("dw_g_ramstore", ramstore,    32'hDEADBEEF);
    checkOutput("dw_g_dwait",    32'(dwait),  32'h0);
    checkOutput("dw_g_iwait",    32'(iwait),  32'h1);
    nextCycle();
    dWEN[0] = 1'b0;
    #1;
    checkOutput("dw_bub_ramWEN", 32'(ramWEN), 32'h0);
    checkOutput("dw_bub_iwait",  32'(iwait),  32'h1);
    nextCycle(); #1;
    checkOutput("ir_g_ramREN",  32'(ramREN), 32'h1);
    checkOutput("ir_g_ramaddr", ramaddr,     32'h300);
    checkOutput("ir_g_iwait",   32'(iwait),  32'h0);

    // Both CPUs stream data reads with RAM always ready: grants alternate
    nextCycle();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'hA0, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'hB0, 32'h0);
    for (int k = 0; k < 8; k++) begin
      if (k > 0) nextCycle();
      #1;
      checkOutput($sformatf("rr_addr_%0d", k),  ramaddr,     expAddr[k]);
      checkOutput($sformatf("rr_dwait_%0d", k), 32'(dwait),  32'(expDwait[k]));
    end

    // CPU1 withdraws during BUSY: enables drop at once, pointer still advances
    nextCycle();
    dREN[0]  = 1'b0;
    daddr[1] = 32'hC0;
    ramstate = BUSY;
    #1;
    checkOutput("wd_idle_ramREN", 32'(ramREN), 32'h0);
    nextCycle(); #1;
    checkOutput("wd_g_ramREN",  32'(ramREN), 32'h1);
    checkOutput("wd_g_ramaddr", ramaddr,     32'hC0);
    dREN[1] = 1'b0;
    #1;
    checkOutput("wd_drop_ramREN", 32'(ramREN), 32'h0);
    checkOutput("wd_drop_ramWEN", 32'(ramWEN), 32'h0);
    checkOutput("wd_drop_dwait",  32'(dwait),  32'h0);
    nextCycle();
    dREN = 2'b11;
    #1;
    checkOutput("wd_idle2_ramREN", 32'(ramREN), 32'h0);

    // ERROR is retried: grant to CPU0 held for three ERROR cycles
    nextCycle();
    ramstate = ERROR;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) nextCycle();
      #1;
      checkOutput($sformatf("err_ramaddr_%0d", k), ramaddr,     32'hA0);
      checkOutput($sformatf("err_ramREN_%0d", k),  32'(ramREN), 32'h1);
      checkOutput($sformatf("err_dwait_%0d", k),   32'(dwait),  32'h3);
    end
    nextCycle();
    ramstate = ACCESS;
    ramload  = 32'hCAFE0001;
    #1;
    checkOutput("err_acc_dwait", 32'(dwait), 32'h2);
    checkOutput("err_acc_dload", dload[0],   32'hCAFE0001);

    // CPU1 write interrupted by reset; afterwards pointer restarts at CPU0
    nextCycle();
    dREN     = 2'b00;
    dWEN[1]  = 1'b1;
    dstore[1] = 32'h55AA;
    ramstate = BUSY;
    #1;
    checkOutput("rs_idle_ramWEN", 32'(ramWEN), 32'h0);
    nextCycle(); #1;
    checkOutput("rs_g_ramWEN",   32'(ramWEN), 32'h1);
    checkOutput("rs_g_ramstore", ramstore,    32'h55AA);
    nRST = 1'b0;
    #1;
    checkOutput("rs_low_ramWEN", 32'(ramWEN), 32'h0);
    checkOutput("rs_low_ramREN", 32'(ramREN), 32'h0);
    checkOutput("rs_low_dwait",  32'(dwait),  32'h2);
    dREN[0]  = 1'b1;
    daddr[0] = 32'hA0;
    #1;
    nRST = 1'b1;
    ramstate = ACCESS;
    #1;
    checkOutput("rs_rel_ramWEN", 32'(ramWEN), 32'h0);
    nextCycle(); #1;
    checkOutput("rs_g0_ramREN",  32'(ramREN), 32'h1);
    checkOutput("rs_g0_ramaddr", ramaddr,     32'hA0);
    checkOutput("rs_g0_dwait",   32'(dwait),  32'h2);
    nextCycle();
    dREN[0] = 1'b0;
    #1;
    nextCycle(); #1;
    checkOutput("rs_g1_ramWEN",   32'(ramWEN), 32'h1);
    checkOutput("rs_g1_ramstore", ramstore,    32'h55AA);
    checkOutput("rs_g1_dwait",    32'(dwait),  32'h0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
